// File: rtl/ftdi_receiver.sv
// ftdi_receiver
//   UART receive path for the FTDI link (8N1, LSB first). The serial line is
//   brought into the clock domain by a two-flop synchroniser, a start edge is
//   detected in IDLE and each bit is sampled in the middle of its period by a
//   reloading down-counter. Completed bytes are presented on rx_data/rx_valid.
//
//   Handshake: rx_valid high means rx_data holds an unconsumed byte. The
//   consumer takes it by asserting rx_ack for a cycle while rx_valid is high;
//   rx_valid clears on the following cycle. rx_ack with rx_valid low is
//   ignored. A byte delivered in the same cycle as rx_ack replaces the old one
//   and keeps rx_valid high. A byte delivered while rx_valid is high and no
//   rx_ack is present overwrites rx_data and pulses overrun.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   FTDI_TX      serial line from the FTDI chip, idle high, asynchronous
//   rx_ack       consumer accepts the byte on rx_data
//   rx_data      last received byte
//   rx_valid     rx_data holds an unconsumed byte
//   frame_error  one-cycle pulse, stop bit sampled low
//   overrun      one-cycle pulse, byte completed while rx_valid was high
//   FTDI_RTS     ready to receive (!rx_valid)
//   busy         receiver is not in IDLE
//   dbg_state    current FSM state encoding, for observation only
module ftdi_receiver #(
    parameter int FREQUENCY = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FTDI_TX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       FTDI_RTS,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
    localparam logic [CNT_WIDTH-1:0] HALF_LOAD = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_LOAD = CNT_WIDTH'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;

    logic rx_s;
    logic cnt_zero;
    logic deliver;
    logic stop_bad;

    assign rx_s     = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        sync_d        = {sync_q[0], FTDI_TX};
        rx_prev_d     = rx_s;
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        deliver       = 1'b0;
        stop_bad      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Falling edge of the synchronised line starts a frame.
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (!rx_s) begin
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        // Line is high again at mid start bit: a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    // Bits arrive LSB first, so shift in from the top.
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break is not
                // decoded as a stream of 0x00 bytes.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end
        overrun_d     = deliver && rx_valid_q && !rx_ack;
        frame_error_d = stop_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign FTDI_RTS    = !rx_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ftdi_receiver.sv
// tb_ftdi_receiver
//   Bench for ftdi_receiver at 16 clocks per bit. Expected bytes go into
//   exp_q when a frame is driven and are popped when rx_valid shows up.
module tb_ftdi_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       reset;
    logic       FTDI_TX;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       FTDI_RTS;
    logic       busy;
    logic [2:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    ftdi_receiver #(
        .FREQUENCY(16),
        .BAUD_RATE(1),
        .CNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .FTDI_TX    (FTDI_TX),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .FTDI_RTS   (FTDI_RTS),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- drivers ----------------
    // Called on a falling clock edge; the start bit begins immediately.
    task automatic send_byte(input logic [7:0] b, input int p);
        FTDI_TX = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            FTDI_TX = b[i];
            repeat (p) @(negedge clk);
        end
        FTDI_TX = 1'b1;
        repeat (p) @(negedge clk);
    endtask

    // Byte seen by a receiver sampling the line at its nominal instants:
    // data bit n is taken HALF + (n+1)*CPB clocks after the start edge.
    // With a mismatched bit period the sample points drift across the frame.
    function automatic logic [7:0] line_model(input logic [7:0] b, input int p);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) begin
            int idx;
            int k;
            idx = HALF + CPB * (n + 1);
            k   = idx / p;
            if (k == 0)      r[n] = 1'b0;
            else if (k <= 8) r[n] = b[k-1];
            else             r[n] = 1'b1;
        end
        return r;
    endfunction

    task automatic ack_pulse(input string tag);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL %s rx_valid got %b want 0", tag, rx_valid);
        else pass_cnt++;
        total_cnt++;
        if (FTDI_RTS !== 1'b1) $display("FAIL %s FTDI_RTS got %b want 1", tag, FTDI_RTS);
        else pass_cnt++;
    endtask

    // Drive one frame, wait for rx_valid and check it against the scoreboard.
    task automatic run_frame(input logic [7:0] b, input int p, input logic [7:0] e,
                             input bit check_lat, input string tag);
        int lat;
        int fe;
        int ov;
        bit seen;
        logic busy2;
        logic busy3;
        logic [7:0] exp_b;
        exp_q.push_back(e);
        lat = 0; fe = 0; ov = 0; seen = 1'b0; busy2 = 1'bx; busy3 = 1'bx;
        fork
            send_byte(b, p);
            begin
                for (int c = 1; c <= 400 && !seen; c++) begin
                    @(negedge clk);
                    if (c == 2) busy2 = busy;
                    if (c == 3) busy3 = busy;
                    if (frame_error === 1'b1) fe++;
                    if (overrun === 1'b1) ov++;
                    if (rx_valid === 1'b1) begin
                        seen = 1'b1;
                        lat  = c;
                    end
                end
            end
        join
        total_cnt++;
        if (!seen) $display("FAIL %s rx_valid timeout got 0 want 1 within 400 cycles", tag);
        else pass_cnt++;
        if (check_lat) begin
            total_cnt++;
            if (lat < 152 || lat > 156) $display("FAIL %s latency got %0d want 152..156", tag, lat);
            else pass_cnt++;
            total_cnt++;
            if (busy2 !== 1'b0 || busy3 !== 1'b1)
                $display("FAIL %s busy edge got %b%b want 01 at cycles 2,3", tag, busy2, busy3);
            else pass_cnt++;
        end
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard empty got 0 entries want 1", tag);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) $display("FAIL %s rx_data got %h want %h", tag, rx_data, exp_b);
            else pass_cnt++;
        end
        total_cnt++;
        if (fe != 0 || ov != 0) $display("FAIL %s error pulses got fe=%0d ov=%0d want 0,0", tag, fe, ov);
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; FTDI_TX = 1'b1; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (rx_data !== 8'h00) $display("FAIL reset rx_data got %h want 00", rx_data); else pass_cnt++;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL reset rx_valid got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++;
        if (frame_error !== 1'b0) $display("FAIL reset frame_error got %b want 0", frame_error); else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset overrun got %b want 0", overrun); else pass_cnt++;
        total_cnt++;
        if (FTDI_RTS !== 1'b1) $display("FAIL reset FTDI_RTS got %b want 1", FTDI_RTS); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_nominal();
        logic [7:0] pats[5];
        pats = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
        for (int i = 0; i < 5; i++) begin
            run_frame(pats[i], CPB, pats[i], 1'b1, $sformatf("nominal_%h", pats[i]));
            ack_pulse("nominal_ack");
        end
    endtask

    task automatic test_back_to_back();
        int ov;
        bit first_seen;
        logic [7:0] exp_b;
        ov = 0; first_seen = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        fork
            begin
                send_byte(8'h3C, CPB);
                send_byte(8'hC3, CPB);
            end
            begin
                for (int c = 1; c <= 340; c++) begin
                    @(negedge clk);
                    if (overrun === 1'b1) ov++;
                    if (!first_seen && rx_valid === 1'b1) begin
                        first_seen = 1'b1;
                        exp_b = exp_q.pop_front();
                        total_cnt++;
                        if (rx_data !== exp_b) $display("FAIL b2b_first rx_data got %h want %h", rx_data, exp_b);
                        else pass_cnt++;
                    end
                end
            end
        join
        total_cnt++;
        if (!first_seen) $display("FAIL b2b_first rx_valid got 0 want 1");
        else pass_cnt++;
        total_cnt++;
        if (ov != 1) $display("FAIL b2b_overrun pulses got %0d want 1", ov);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL b2b_second scoreboard empty got 0 entries want 1");
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b || rx_valid !== 1'b1)
                $display("FAIL b2b_second rx_data/valid got %h/%b want %h/1", rx_data, rx_valid, exp_b);
            else pass_cnt++;
        end
        ack_pulse("b2b_ack");
    endtask

    task automatic test_ack_same_cycle();
        int ov;
        logic v155;
        logic [7:0] d155;
        logic [7:0] exp_b;
        run_frame(8'h3C, CPB, 8'h3C, 1'b0, "same_pre");
        ov = 0; v155 = 1'bx; d155 = 8'hxx;
        exp_q.push_back(8'hC3);
        fork
            send_byte(8'hC3, CPB);
            begin
                for (int c = 1; c <= 170; c++) begin
                    @(negedge clk);
                    if (overrun === 1'b1) ov++;
                    // Delivery edge is the 155th rising edge after the start edge.
                    if (c == 154) rx_ack = 1'b1;
                    if (c == 155) begin
                        rx_ack = 1'b0;
                        v155   = rx_valid;
                        d155   = rx_data;
                    end
                end
            end
        join
        total_cnt++;
        if (ov != 0) $display("FAIL same_cycle overrun pulses got %0d want 0", ov);
        else pass_cnt++;
        total_cnt++;
        if (v155 !== 1'b1) $display("FAIL same_cycle rx_valid got %b want 1", v155);
        else pass_cnt++;
        total_cnt++;
        exp_b = exp_q.pop_front();
        if (d155 !== exp_b) $display("FAIL same_cycle rx_data got %h want %h", d155, exp_b);
        else pass_cnt++;
        ack_pulse("same_cycle_ack");
    endtask

    task automatic test_break();
        int fe;
        int vc;
        int busy_low;
        logic busy_hold;
        logic busy_after;
        fe = 0; vc = 0; busy_low = 0; busy_hold = 1'bx; busy_after = 1'bx;
        FTDI_TX = 1'b0;
        for (int c = 1; c <= 12 * CPB; c++) begin
            @(negedge clk);
            if (frame_error === 1'b1) fe++;
            if (rx_valid === 1'b1) vc++;
            if (c >= 3 && busy !== 1'b1) busy_low++;
        end
        FTDI_TX = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (frame_error === 1'b1) fe++;
            if (rx_valid === 1'b1) vc++;
            if (c == 1) busy_hold = busy;
            if (c == 8) busy_after = busy;
        end
        total_cnt++;
        if (fe != 1) $display("FAIL break frame_error pulses got %0d want 1", fe); else pass_cnt++;
        total_cnt++;
        if (vc != 0) $display("FAIL break rx_valid cycles got %0d want 0", vc); else pass_cnt++;
        total_cnt++;
        if (busy_low != 0 || busy_hold !== 1'b1)
            $display("FAIL break busy_hold got low=%0d hold=%b want 0,1", busy_low, busy_hold);
        else pass_cnt++;
        total_cnt++;
        if (busy_after !== 1'b0) $display("FAIL break busy_release got %b want 0", busy_after); else pass_cnt++;
        run_frame(8'h55, CPB, 8'h55, 1'b1, "after_break");
        ack_pulse("after_break_ack");
    endtask

    task automatic test_glitch();
        int act;
        logic busy_mid;
        logic busy_late;
        act = 0; busy_mid = 1'bx; busy_late = 1'bx;
        FTDI_TX = 1'b0;
        repeat (4) @(negedge clk);
        FTDI_TX = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (rx_valid === 1'b1 || frame_error === 1'b1 || overrun === 1'b1) act++;
            if (c == 1) busy_mid = busy;
            if (c == 20) busy_late = busy;
        end
        total_cnt++;
        if (busy_mid !== 1'b1) $display("FAIL glitch busy_start got %b want 1", busy_mid); else pass_cnt++;
        total_cnt++;
        if (busy_late !== 1'b0) $display("FAIL glitch busy_idle got %b want 0", busy_late); else pass_cnt++;
        total_cnt++;
        if (act != 0) $display("FAIL glitch output activity got %0d want 0", act); else pass_cnt++;
    endtask

    task automatic test_tolerance();
        int periods[2];
        periods = '{15, 17};
        for (int i = 0; i < 2; i++) begin
            run_frame(8'h96, periods[i], line_model(8'h96, periods[i]), 1'b0,
                      $sformatf("baud_%0d", periods[i]));
            ack_pulse("baud_ack");
        end
    endtask

    task automatic test_reset_mid();
        run_frame(8'hAA, CPB, 8'hAA, 1'b0, "pre_reset");
        fork
            send_byte(8'h12, CPB);
            begin
                // Cycle 88 is the middle of data bit 4.
                repeat (HALF + 5 * CPB) @(negedge clk);
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL reset_mid busy_before got %b want 1", busy); else pass_cnt++;
                #2 reset = 1'b0;
                #1;
                total_cnt++;
                if (rx_valid !== 1'b0 || rx_data !== 8'h00 || FTDI_RTS !== 1'b1 ||
                    busy !== 1'b0 || frame_error !== 1'b0 || overrun !== 1'b0)
                    $display("FAIL reset_mid outputs got v=%b d=%h rts=%b busy=%b fe=%b ov=%b want 0 00 1 0 0 0",
                             rx_valid, rx_data, FTDI_RTS, busy, frame_error, overrun);
                else pass_cnt++;
            end
        join
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(8'h7E, CPB, 8'h7E, 1'b1, "after_reset");
        ack_pulse("after_reset_ack");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset   = 1'b0;
        FTDI_TX = 1'b1;
        rx_ack  = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_ack_same_cycle();
        test_break();
        test_glitch();
        test_tolerance();
        test_reset_mid();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain entries got %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
